// File: rtl/drp_responder.sv
// DRP target: answers DEN/DWE/DADDR/DI requests with DO/DRDY after a fixed
// LATENCY from a local map of status words and RW config registers.
// Ports: clock, reset_n (async, active low), drp_den/dwe/daddr/di in,
// drp_do/drp_drdy out, status[255:0] in, cfg[127:0] out, protocol_err out.
// Option: define DRP_RESPONDER_ERRCNT_EN for a rejection counter at 0x3F.
module drp_responder #(
  parameter int LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         drp_den,
  input  logic         drp_dwe,
  input  logic [6:0]   drp_daddr,
  input  logic [15:0]  drp_di,
  output logic [15:0]  drp_do,
  output logic         drp_drdy,
  input  logic [255:0] status,
  output logic [127:0] cfg,
  output logic         protocol_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  localparam bit DIRECT = (LATENCY == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [6:0]  req_addr;
  logic        req_we;
  logic [15:0] req_di;
  logic [15:0] regs [32];

  logic        accept;
  logic        reject;
  logic        fire;
  logic [6:0]  a;
  logic        we;
  logic [15:0] d;
  logic [15:0] rdata;
  logic [15:0] errcnt_rd;

  assign accept = (state == IDLE) && drp_den;
  assign reject = (state != IDLE) && drp_den;
  // With LATENCY=1 the response is produced on the accepting edge itself.
  assign fire = (accept && DIRECT) ||
                ((state == WAIT) && (cnt == 4'd1));

  // Direct path uses the live request; otherwise the latched one.
  always_comb begin
    a  = req_addr;
    we = req_we;
    d  = req_di;
    if (state == IDLE) begin
      a  = drp_daddr;
      we = drp_dwe;
      d  = drp_di;
    end
  end

  always_comb begin
    rdata = 16'h0;
    unique case (1'b1)
      (a[6:4] == 3'b000): rdata = status[{a[3:0], 4'b0000} +: 16];
      (a == 7'h3F):       rdata = errcnt_rd;
      (a[6:5] == 2'b10):  rdata = regs[a[4:0]];
      default:            rdata = 16'h0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_addr     <= 7'd0;
      req_we       <= 1'b0;
      req_di       <= 16'h0;
      drp_do       <= 16'h0;
      drp_drdy     <= 1'b0;
      protocol_err <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 16'h0;
    end else begin
      drp_drdy     <= fire;
      protocol_err <= reject;
      unique case (state)
        IDLE: if (drp_den) begin
          req_addr <= drp_daddr;
          req_we   <= drp_dwe;
          req_di   <= drp_di;
          cnt      <= LOAD;
          state    <= DIRECT ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        drp_do <= we ? 16'h0 : rdata;
        if (we && (a[6:5] == 2'b10)) regs[a[4:0]] <= d;
      end
    end
  end

`ifdef DRP_RESPONDER_ERRCNT_EN
  logic [15:0] errcnt;

  // A clearing write beats a rejection landing on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      errcnt <= 16'h0;
    end else if (fire && we && (a == 7'h3F)) begin
      errcnt <= 16'h0;
    end else if (reject && (errcnt != 16'hFFFF)) begin
      errcnt <= errcnt + 16'd1;
    end
  end

  assign errcnt_rd = errcnt;
`else
  assign errcnt_rd = 16'h0;
`endif

  for (genvar n = 0; n < 8; n++) begin : g_cfg
    assign cfg[16*n +: 16] = regs[n];
  end

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: LATENCY=4 and LATENCY=1 instances on shared inputs,
// checked every cycle against a transaction-level reference model.
module tb_drp_responder;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         den;
  logic         dwe;
  logic [6:0]   daddr;
  logic [15:0]  di;
  logic [255:0] status;

  logic [15:0]  do4, do1;
  logic         drdy4, drdy1;
  logic [127:0] cfg4, cfg1;
  logic         perr4, perr1;

  always #5 clock = ~clock;

  drp_responder #(.LATENCY(4)) u4 (
    .clock(clock), .reset_n(reset_n),
    .drp_den(den), .drp_dwe(dwe), .drp_daddr(daddr), .drp_di(di),
    .drp_do(do4), .drp_drdy(drdy4),
    .status(status), .cfg(cfg4), .protocol_err(perr4)
  );

  drp_responder #(.LATENCY(1)) u1 (
    .clock(clock), .reset_n(reset_n),
    .drp_den(den), .drp_dwe(dwe), .drp_daddr(daddr), .drp_di(di),
    .drp_do(do1), .drp_drdy(drdy1),
    .status(status), .cfg(cfg1), .protocol_err(perr1)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  bit chk_do = 0;

  int          lat [2] = '{4, 1};
  int          busy_end [2];
  int          resp_edge [2];
  bit          pend [2];
  logic [6:0]  p_addr [2];
  bit          p_we [2];
  logic [15:0] p_di [2];
  logic [15:0] mregs [2][32];
  int          errc [2];
  bit          e_drdy [2];
  bit          e_perr [2];
  logic [15:0] e_do [2];

  function automatic logic [15:0] rd(int i, logic [6:0] ad);
    if (ad < 7'h10) return status[16*int'(ad) +: 16];
`ifdef DRP_RESPONDER_ERRCNT_EN
    if (ad == 7'h3F) return 16'(errc[i]);
`endif
    if (ad >= 7'h40 && ad <= 7'h5F) return mregs[i][int'(ad) - 64];
    return 16'h0;
  endfunction

  function automatic logic [127:0] ecfg(int i);
    logic [127:0] c;
    for (int n = 0; n < 8; n++) c[16*n +: 16] = mregs[i][n];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_end[i] = -1;
      pend[i] = 0;
      errc[i] = 0;
      e_drdy[i] = 0;
      e_perr[i] = 0;
      e_do[i] = 16'h0;
      for (int r = 0; r < 32; r++) mregs[i][r] = 16'h0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit rej;
      bit clr;
      rej = den && (edge_n <= busy_end[i]);
      clr = 0;
      e_drdy[i] = 0;
      e_perr[i] = 0;
      if (den && !rej) begin
        busy_end[i] = edge_n + lat[i];
        resp_edge[i] = edge_n + lat[i] - 1;
        pend[i] = 1;
        p_addr[i] = daddr;
        p_we[i] = dwe;
        p_di[i] = di;
      end
      if (pend[i] && edge_n == resp_edge[i]) begin
        pend[i] = 0;
        e_drdy[i] = 1;
        if (p_we[i]) begin
          e_do[i] = 16'h0;
          if (p_addr[i] >= 7'h40 && p_addr[i] <= 7'h5F)
            mregs[i][int'(p_addr[i]) - 64] = p_di[i];
`ifdef DRP_RESPONDER_ERRCNT_EN
          if (p_addr[i] == 7'h3F) begin
            errc[i] = 0;
            clr = 1;
          end
`endif
        end else begin
          e_do[i] = rd(i, p_addr[i]);
        end
      end
      if (rej) begin
        e_perr[i] = 1;
`ifdef DRP_RESPONDER_ERRCNT_EN
        if (!clr && errc[i] < 16'hFFFF) errc[i]++;
`endif
      end
    end
  endtask

  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %h expected %h",
             tag, edge_n, act, exp);
    end
  endtask

  task automatic check_all();
    chk("drdy4", 128'(drdy4), 128'(e_drdy[0]));
    chk("perr4", 128'(perr4), 128'(e_perr[0]));
    chk("cfg4", cfg4, ecfg(0));
    if (e_drdy[0] || chk_do) chk("do4", 128'(do4), 128'(e_do[0]));
    chk("drdy1", 128'(drdy1), 128'(e_drdy[1]));
    chk("perr1", 128'(perr1), 128'(e_perr[1]));
    chk("cfg1", cfg1, ecfg(1));
    if (e_drdy[1] || chk_do) chk("do1", 128'(do1), 128'(e_do[1]));
  endtask

  task automatic cyc(bit v, bit w, logic [6:0] ad, logic [15:0] dat);
    den = v;
    dwe = w;
    daddr = ad;
    di = dat;
    @(posedge clock);
    edge_n++;
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 7'h0, 16'h0);
  endtask

  task automatic tx(bit w, logic [6:0] ad, logic [15:0] dat);
    cyc(1, w, ad, dat);
    idle(5);
  endtask

  task automatic rst_pulse();
    den = 0;
    reset_n = 0;
    model_reset();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    chk_do = 1;
    check_all();
    chk_do = 0;
    reset_n = 1;
  endtask

  task automatic set_word(int n, logic [15:0] v);
    status[16*n +: 16] = v;
  endtask

  initial begin
    den = 0;
    dwe = 0;
    daddr = 7'h0;
    di = 16'h0;
    status = '0;
    for (int n = 0; n < 16; n++) set_word(n, 16'(n * 16'h1111));
    reset_n = 1;
    @(negedge clock);
    rst_pulse();
    idle(5);

    tx(0, 7'h45, 16'h0);
    tx(1, 7'h41, 16'hBEEF);
    tx(0, 7'h41, 16'h0);

    set_word(3, 16'h1234);
    cyc(1, 0, 7'h03, 16'h0);
    set_word(3, 16'h5678);
    idle(5);
    tx(1, 7'h03, 16'hFFFF);
    tx(0, 7'h03, 16'h0);

    cyc(1, 0, 7'h10, 16'h0);
    idle(1);
    cyc(1, 1, 7'h42, 16'h1111);
    idle(5);
    tx(0, 7'h3F, 16'h0);
    tx(1, 7'h3F, 16'h1234);
    tx(0, 7'h3F, 16'h0);

    cyc(1, 1, 7'h44, 16'hC0DE);
    idle(1);
    cyc(1, 0, 7'h44, 16'h0);
    cyc(1, 0, 7'h45, 16'h0);
    idle(5);

    tx(1, 7'h4F, 16'h5A5A);
    tx(1, 7'h60, 16'hDEAD);
    tx(0, 7'h60, 16'h0);
    tx(0, 7'h4F, 16'h0);

    cyc(1, 1, 7'h40, 16'hAAAA);
    idle(1);
    rst_pulse();
    idle(2);
    tx(0, 7'h40, 16'h0);

    for (int t = 0; t < 600; t++) begin
      logic [6:0] ad;
      int sel;
      for (int n = 0; n < 8; n++) status[32*n +: 32] = $urandom;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: ad = 7'($urandom_range(0, 15));
        1: ad = 7'h3F;
        2: ad = 7'($urandom_range(64, 71));
        3: ad = 7'($urandom_range(72, 95));
        4: ad = 7'($urandom_range(16, 62));
        default: ad = 7'($urandom_range(96, 127));
      endcase
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cyc($urandom_range(0, 2) == 0, 1'($urandom), ad,
               16'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drp_responder.md
# drp_responder

DRP responder: the target end of the Xilinx dynamic reconfiguration port handshake that our host wrappers drive, e.g. the XADC wrapper with DEN/DWE/DADDR/DI out and DO/DRDY back. It answers DRP transactions from a local register map with a fixed, parameterised latency. The map holds read-only status words fed from fabric and read/write configuration registers exported to fabric. It serves two roles: a soft DRP target for custom blocks sharing the host-side DRP wrapper, and a cycle-accurate stand-in for hard DRP primitives in simulation.

## Interface
- LATENCY, 4: cycles from the DEN sample edge to DRDY. Legal range 1..15.
- clock  input  1  DRP clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- drp_den  input  1  request strobe, one cycle per transaction.
- drp_dwe  input  1  write enable, sampled with drp_den.
- drp_daddr  input  7  register address, sampled with drp_den.
- drp_di  input  16  write data, sampled with drp_den.
- drp_do  output  16  read data; valid while drp_drdy is high.
- drp_drdy  output  1  one-cycle transaction-complete pulse.
- status  input  256  sixteen 16-bit read-only words; word n is status[16n+15:16n].
- cfg  output  128  RW registers 0x40..0x47; word n is cfg[16n+15:16n].
- protocol_err  output  1  one-cycle pulse when a request is rejected.

## Operation
- Address map:
  - 0x00–0x0F: status words, read-only. Writes are ignored but still acknowledged.
  - 0x10–0x3E: reads return 0; writes are ignored.
  - 0x3F: error counter if enabled (see Configuration), else reads 0.
  - 0x40–0x5F: 32 RW registers.
  - 0x60–0x7F: reads return 0; writes are ignored.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting latency.
  - RESP: drp_drdy high for one cycle.
- Transitions:
  - IDLE -> WAIT on drp_den. Address, dwe and di are latched into request registers and the counter is loaded with LATENCY-1.
  - WAIT -> RESP when the counter reaches 0. With LATENCY=1, IDLE -> RESP directly.
  - RESP -> IDLE unconditionally.
- Read: data is selected from the latched address and registered into drp_do on the edge entering RESP. Status is therefore sampled at that edge, not at DEN.
- Write: the register update and cfg update happen on the same edge that raises drp_drdy. drp_do is driven 0 during a write response.
- drp_do holds its last value outside RESP. Verification may only check it while drp_drdy is high.
- Busy window: from the edge after the DEN sample through the RESP cycle, inclusive.
  - drp_den in this window is rejected: no state change, no second DRDY, request data discarded.
  - protocol_err pulses on the following cycle.
- Reset, any time:
  - State returns to IDLE; drp_drdy=0, drp_do=0, protocol_err=0.
  - All RW registers and cfg are 0; the error counter is 0.
  - An in-flight transaction is aborted: no DRDY, and a pending write is not committed.

## Timing
- drp_den high at edge k -> drp_drdy high for exactly cycle k+LATENCY.
- Back-to-back: the earliest accepted next DEN is at edge k+LATENCY+1, giving a throughput of one transaction per LATENCY+1 cycles.
- cfg reflects a write from cycle k+LATENCY onward, the same cycle drp_drdy is high.
- protocol_err is high the cycle after the offending DEN edge.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- DRP_RESPONDER_ERRCNT_EN:
  - Defined: a 16-bit counter increments on every rejected request and saturates at 0xFFFF. It reads at 0x3F.
  - Writing any value to 0x3F clears the counter to 0 at the write's DRDY edge. If a rejection occurs in that same cycle, the clear wins.
  - Undefined: no counter logic is built; 0x3F reads 0 and writes to it are ignored. protocol_err is present in both builds.

## Test plan
- Reset then read, LATENCY=4: DEN at edge 10 with addr 0x45 -> drp_drdy high only in cycle 14, drp_do=0x0000, cfg=0.
- Write 0xBEEF to 0x41 (DWE=1), then read 0x41 -> first drp_drdy shows drp_do=0x0000 and cfg[31:16]=0xBEEF in the same cycle; the read returns 0xBEEF.
- status word 3 = 0x1234 at DEN, changed to 0x5678 before DRDY, read 0x03 -> 0x5678. A write of 0xFFFF to 0x03 is acknowledged, and a re-read still returns status.
- Second DEN two cycles after the first, LATENCY=4 -> a single DRDY at k+4, protocol_err pulse at k+3. With DRP_RESPONDER_ERRCNT_EN, reading 0x3F returns 0x0001; writing 0x3F then re-reading returns 0x0000.
- LATENCY=1, DEN at edges 5 and 7 -> DRDY in cycles 6 and 8, no protocol_err. DEN at edge 6 instead of 7 -> rejected.
- Write 0xAAAA to 0x40 with reset_n pulsed low in cycle k+2 -> no DRDY, cfg[15:0] stays 0, and a subsequent read of 0x40 returns 0x0000.
